// File: rtl/ll_arb_pkg.sv
// Shared constants and width helpers for the linked-list FIFO arbiter.
package ll_arb_pkg;

  localparam int WIDTH_DEF     = 8;
  localparam int DEPTH_DEF     = 4;
  localparam int NUM_FIFOS_DEF = 2;
  localparam int QUOTA_DEF     = DEPTH_DEF - 1;

  // A single requester still gets a 1-bit selector so ports never collapse to zero width.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int SEL_W_DEF = sel_w(NUM_FIFOS_DEF);
  localparam int CNT_W_DEF = cnt_w(DEPTH_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module rr_arbiter
  import ll_arb_pkg::*;
#(
  parameter int N = NUM_FIFOS_DEF
) (
  input  logic [N-1:0]          req,
  input  logic [sel_w(N)-1:0]   ptr,
  output logic [N-1:0]          gnt,
  output logic                  valid,
  output logic [sel_w(N)-1:0]   index
);

  localparam int IW = sel_w(N);

  always_comb begin
    int j;
    gnt   = '0;
    valid = 1'b0;
    index = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        index  = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ll_fifo_arbiter.sv
// Push/pop arbitration and per-FIFO occupancy tracking in front of a shared
// linked-list FIFO pool; pop results are registered one cycle after the grant.
module ll_fifo_arbiter
  import ll_arb_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int NUM_FIFOS = NUM_FIFOS_DEF,
  parameter int QUOTA     = DEPTH - 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_FIFOS-1:0]                  push_req,
  input  logic [NUM_FIFOS*WIDTH-1:0]            push_data,
  output logic [NUM_FIFOS-1:0]                  push_gnt,
  input  logic [NUM_FIFOS-1:0]                  pop_req,
  output logic [NUM_FIFOS-1:0]                  pop_gnt,
  output logic [WIDTH-1:0]                      pop_data,
  output logic                                  pop_vld,
  output logic [sel_w(NUM_FIFOS)-1:0]           pop_id,
  output logic                                  ll_push,
  output logic                                  ll_pop,
  output logic [sel_w(NUM_FIFOS)-1:0]           ll_push_sel,
  output logic [sel_w(NUM_FIFOS)-1:0]           ll_pop_sel,
  output logic [WIDTH-1:0]                      ll_data_in,
  input  logic                                  ll_full,
  input  logic [NUM_FIFOS-1:0]                  ll_empty,
  input  logic [WIDTH-1:0]                      ll_data_out,
  output logic [NUM_FIFOS*cnt_w(DEPTH)-1:0]     count,
  output logic                                  err
);

  localparam int SW = sel_w(NUM_FIFOS);
  localparam int CW = cnt_w(DEPTH);

  logic [CW-1:0]        count_q [NUM_FIFOS];
  logic [CW-1:0]        count_d [NUM_FIFOS];
  logic [SW-1:0]        push_ptr_q, push_ptr_d;
  logic [SW-1:0]        pop_ptr_q, pop_ptr_d;
  logic                 pop_vld_q, pop_vld_d;
  logic [WIDTH-1:0]     pop_data_q, pop_data_d;
  logic [SW-1:0]        pop_id_q, pop_id_d;
  logic                 err_q, err_d;
  logic [NUM_FIFOS-1:0] push_elig, pop_elig, mismatch;
  logic                 room;
  int                   total_cnt;

  // Pool-wide guard backs up ll_full so the summed occupancy can never pass DEPTH.
  always_comb begin
    total_cnt = 0;
    for (int i = 0; i < NUM_FIFOS; i++) total_cnt += int'(count_q[i]);
  end
  assign room = (total_cnt < DEPTH);

  for (genvar gi = 0; gi < NUM_FIFOS; gi++) begin : g_fifo
    assign push_elig[gi] = rst & push_req[gi] & ~ll_full & room & (count_q[gi] < CW'(QUOTA));
    assign pop_elig[gi]  = rst & pop_req[gi] & ~ll_empty[gi] & (count_q[gi] != '0);
    assign mismatch[gi]  = (count_q[gi] == '0) != ll_empty[gi];
    assign count[gi*CW +: CW] = count_q[gi];
  end

  rr_arbiter #(.N(NUM_FIFOS)) u_push_arb (
    .req   (push_elig),
    .ptr   (push_ptr_q),
    .gnt   (push_gnt),
    .valid (ll_push),
    .index (ll_push_sel)
  );

  rr_arbiter #(.N(NUM_FIFOS)) u_pop_arb (
    .req   (pop_elig),
    .ptr   (pop_ptr_q),
    .gnt   (pop_gnt),
    .valid (ll_pop),
    .index (ll_pop_sel)
  );

  assign ll_data_in = ll_push ? push_data[ll_push_sel*WIDTH +: WIDTH] : '0;

  always_comb begin
    push_ptr_d = push_ptr_q;
    pop_ptr_d  = pop_ptr_q;
    if (ll_push) push_ptr_d = (ll_push_sel == SW'(NUM_FIFOS - 1)) ? '0 : ll_push_sel + SW'(1);
    if (ll_pop)  pop_ptr_d  = (ll_pop_sel == SW'(NUM_FIFOS - 1)) ? '0 : ll_pop_sel + SW'(1);
    pop_vld_d  = ll_pop;
    pop_data_d = pop_data_q;
    pop_id_d   = pop_id_q;
    if (ll_pop) begin
      pop_data_d = ll_data_out;
      pop_id_d   = ll_pop_sel;
    end
    err_d = err_q | (|mismatch);
    for (int i = 0; i < NUM_FIFOS; i++)
      count_d[i] = count_q[i] + CW'(push_gnt[i]) - CW'(pop_gnt[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      push_ptr_q <= '0;
      pop_ptr_q  <= '0;
      pop_vld_q  <= 1'b0;
      pop_data_q <= '0;
      pop_id_q   <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < NUM_FIFOS; i++) count_q[i] <= '0;
    end else begin
      push_ptr_q <= push_ptr_d;
      pop_ptr_q  <= pop_ptr_d;
      pop_vld_q  <= pop_vld_d;
      pop_data_q <= pop_data_d;
      pop_id_q   <= pop_id_d;
      err_q      <= err_d;
      for (int i = 0; i < NUM_FIFOS; i++) count_q[i] <= count_d[i];
    end
  end

  assign pop_vld  = pop_vld_q;
  assign pop_data = pop_data_q;
  assign pop_id   = pop_id_q;
  assign err      = err_q;

endmodule
